dwrr_queue_bank: RTL and testbench
==================================

# dwrr_queue_bank

Requestor-side companion to the DWRR arbiter. Holds one FIFO of fixed-size packets per requestor, drives the arbiter's `reqs` vector from FIFO occupancy, and on each `gnt` dequeues the granted packet into a registered output stage tagged with its requestor index. Sits between the per-flow ingress logic and the shared egress link that the arbiter schedules.

## Interface
Parameters:
- `NUM_REQS`, 4, number of queues; must match the arbiter.
- `DWID`, 8, packet data width in bits.
- `DEPTH`, 4, entries per queue; power of two, ≥2.
- `CNTWID`, `$clog2(NUM_REQS)`, width of the output queue index.
- `PTRWID`, `$clog2(DEPTH)`, FIFO pointer width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `push_valid`  in  NUM_REQS  per-queue write strobe.
- `push_data`  in  NUM_REQS*DWID  queue i data at `[(i+1)*DWID-1:i*DWID]`.
- `push_ready`  out  NUM_REQS  queue i not full.
- `reqs`  out  NUM_REQS  to arbiter; queue i non-empty and output not blocked.
- `gnt`  in  NUM_REQS  from arbiter; one-hot or zero.
- `blk`  out  1  to arbiter; output stage stalled.
- `out_valid`  out  1  output packet valid.
- `out_data`  out  DWID  output packet.
- `out_id`  out  CNTWID  queue index of output packet.
- `out_ready`  in  1  downstream accepts output.
- `occupancy`  out  NUM_REQS*(PTRWID+1)  per-queue entry count.
- `err`  out  1  sticky protocol error.

## Operation
- Reset (async, any time, including mid-transfer): all FIFOs empty, pointers 0, `occupancy`=0, `out_valid`=0, `out_data`=0, `out_id`=0, `err`=0; hence `reqs`=0, `blk`=0, `push_ready`=all ones.
- Push: queue i writes `push_data` slice when `push_valid[i] & push_ready[i]`. `push_valid` with `push_ready[i]`=0 is dropped, no error.
- `push_ready[i]` = occupancy ≠ DEPTH, from registered state only; a pop in the same cycle does not free the slot that cycle.
- `blk` = `out_valid & ~out_ready`.
- `reqs[i]` = (occupancy[i] ≠ 0) & ~`blk`. Combinational from registered state plus `out_ready`.
- Pop: `gnt[i]` with `reqs[i]`=1 reads head of queue i into output stage: `out_data`←head, `out_id`←i, `out_valid`←1.
- Output stage: loads on valid pop; otherwise clears `out_valid` when `out_ready`=1; holds when `blk`.
- Simultaneous push and pop on one queue: both happen, occupancy unchanged.
- Pointers wrap modulo DEPTH; occupancy uses PTRWID+1 bits to distinguish full from empty.
- Errors (set `err`, sticky until reset; offending grant ignored, no state change): `gnt` with more than one bit set; `gnt[i]` while `reqs[i]`=0 (empty queue or blocked).

## Timing
- Push in cycle N into empty queue → `occupancy`=1 and `reqs[i]`=1 in N+1; no push-to-grant bypass.
- `gnt` in cycle M → `out_valid`, `out_data`, `out_id` valid in M+1; occupancy decrements in M+1; `reqs[i]` falls in M+1 if that was the last entry.
- Back-to-back grants with `out_ready`=1 give one packet per cycle.
- `out_ready` low with `out_valid` high → `blk`, `reqs` forced 0 in the same cycle; resume the cycle `out_ready` rises.

## Structure
- Shared package `dwrr_pkg`: default `NUM_REQS`, `QWID`, `PSIZE`, `DWID`, `DEPTH`; shared by arbiter and this block.
- One sub-module: `sync_fifo` (params `DWID`, `DEPTH`; push/pop/data/full/empty/count, async reset), instantiated NUM_REQS times in a generate loop. Output stage, `blk`, `reqs` and error logic live at top level.

## Test plan
- Reset mid-traffic: fill queue 0 with 3 entries, assert `rst` between edges → `occupancy`, `reqs`, `out_valid`, `err` 0 immediately; `push_ready`=4'b1111.
- Single flow: push 0x11,0x22 to queue 2; grant `gnt`=4'b0100 two cycles with `out_ready`=1 → out (0x11,id 2) then (0x22,id 2); `reqs[2]` low after second.
- Full/wrap: push 5 entries 0xA0..0xA4 to queue 1 with DEPTH=4 → `push_ready[1]`=0 after 4, 0xA4 dropped; pop 2, push 0xB0,0xB1 → output order A0,A1,A2,A3,B0,B1.
- Backpressure: `out_valid`=1, `out_ready`=0 → `blk`=1, `reqs`=0, output held stable 3 cycles; release → data accepted, `reqs` returns same cycle.
- Simultaneous push/pop on queue 3 at occupancy 2 → occupancy stays 2, FIFO order preserved.
- Protocol error: `gnt`=4'b0011, then `gnt[0]` on empty queue 0 → `err`=1 sticky, no pop, occupancy unchanged.

Source files
------------

// File: rtl/dwrr_pkg.sv
// Defaults shared by the DWRR arbiter and its requestor-side queue bank.
package dwrr_pkg;
    localparam int NUM_REQS = 4;
    localparam int QWID     = 8;
    localparam int PSIZE    = 4;
    localparam int DWID     = 8;
    localparam int DEPTH    = 4;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; caller guarantees no push when full, no pop when empty.
module sync_fifo #(
    parameter  int DWID   = 8,
    parameter  int DEPTH  = 4,
    localparam int PTRWID = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWID-1:0]   push_data,
    input  logic              pop,
    output logic [DWID-1:0]   pop_data,
    output logic              full,
    output logic              empty,
    output logic [PTRWID:0]   count
);
    logic [DWID-1:0]   mem_q [DEPTH];
    logic [PTRWID-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRWID-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRWID:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTRWID'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTRWID'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTRWID+1)'(1);
            2'b01:   count_d = count_q - (PTRWID+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == (PTRWID+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
endmodule

// File: rtl/dwrr_queue_bank.sv
// Per-requestor packet FIFOs feeding the DWRR arbiter; granted heads move into a registered output stage.
module dwrr_queue_bank #(
    parameter  int NUM_REQS = dwrr_pkg::NUM_REQS,
    parameter  int DWID     = dwrr_pkg::DWID,
    parameter  int DEPTH    = dwrr_pkg::DEPTH,
    localparam int CNTWID   = $clog2(NUM_REQS),
    localparam int PTRWID   = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQS-1:0]            push_valid,
    input  logic [NUM_REQS*DWID-1:0]       push_data,
    output logic [NUM_REQS-1:0]            push_ready,
    output logic [NUM_REQS-1:0]            reqs,
    input  logic [NUM_REQS-1:0]            gnt,
    output logic                           blk,
    output logic                           out_valid,
    output logic [DWID-1:0]                out_data,
    output logic [CNTWID-1:0]              out_id,
    input  logic                           out_ready,
    output logic [NUM_REQS*(PTRWID+1)-1:0] occupancy,
    output logic                           err
);
    logic [NUM_REQS-1:0] full, empty, pop;
    logic [DWID-1:0]     head [NUM_REQS];
    logic [PTRWID:0]     cnt  [NUM_REQS];

    logic              out_valid_q, out_valid_d;
    logic [DWID-1:0]   out_data_q, out_data_d;
    logic [CNTWID-1:0] out_id_q, out_id_d;
    logic              err_q, err_d;

    logic              gnt_any, gnt_multi, gnt_bad, pop_ok;
    logic [DWID-1:0]   head_sel;
    logic [CNTWID-1:0] gnt_idx;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_q
        sync_fifo #(.DWID(DWID), .DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_valid[i] & ~full[i]),
            .push_data (push_data[i*DWID +: DWID]),
            .pop       (pop[i]),
            .pop_data  (head[i]),
            .full      (full[i]),
            .empty     (empty[i]),
            .count     (cnt[i])
        );
        assign occupancy[i*(PTRWID+1) +: (PTRWID+1)] = cnt[i];
    end

    assign push_ready = ~full;
    assign blk        = out_valid_q & ~out_ready;
    assign reqs       = ~empty & {NUM_REQS{~blk}};

    // A bad grant is dropped whole: no pop on any queue, only the error flag moves.
    assign gnt_any   = |gnt;
    assign gnt_multi = |(gnt & (gnt - NUM_REQS'(1)));
    assign gnt_bad   = |(gnt & ~reqs);
    assign pop_ok    = gnt_any & ~gnt_multi & ~gnt_bad;
    assign pop       = pop_ok ? gnt : '0;

    always_comb begin
        head_sel = '0;
        gnt_idx  = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (gnt[i]) begin
                head_sel = head[i];
                gnt_idx  = CNTWID'(i);
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        err_d       = err_q | (gnt_any & (gnt_multi | gnt_bad));
        if (pop_ok) begin
            out_valid_d = 1'b1;
            out_data_d  = head_sel;
            out_id_d    = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign err       = err_q;
endmodule

// File: tb/tb_dwrr_queue_bank.sv
// Directed scoreboard bench for dwrr_queue_bank: per-queue model FIFOs predict every dequeued packet.
module tb_dwrr_queue_bank;
    localparam int NQ = 4;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = 2;
    localparam int PW = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NQ-1:0]          push_valid = '0;
    logic [NQ*DW-1:0]       push_data  = '0;
    logic [NQ-1:0]          push_ready;
    logic [NQ-1:0]          reqs;
    logic [NQ-1:0]          gnt = '0;
    logic                   blk;
    logic                   out_valid;
    logic [DW-1:0]          out_data;
    logic [CW-1:0]          out_id;
    logic                   out_ready = 1'b1;
    logic [NQ*(PW+1)-1:0]   occupancy;
    logic                   err;

    int nvec = 0;
    int nerr = 0;

    logic [DW-1:0]    mq0[$], mq1[$], mq2[$], mq3[$];
    logic [CW+DW-1:0] sb[$];

    dwrr_queue_bank #(.NUM_REQS(NQ), .DWID(DW), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .reqs       (reqs),
        .gnt        (gnt),
        .blk        (blk),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .occupancy  (occupancy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int msize(input int q);
        case (q)
            0: return mq0.size();
            1: return mq1.size();
            2: return mq2.size();
            default: return mq3.size();
        endcase
    endfunction

    task automatic mpush(input int q, input logic [DW-1:0] d);
        case (q)
            0: mq0.push_back(d);
            1: mq1.push_back(d);
            2: mq2.push_back(d);
            default: mq3.push_back(d);
        endcase
    endtask

    task automatic mpop_to_sb(input int q);
        logic [DW-1:0] d;
        case (q)
            0: d = mq0.pop_front();
            1: d = mq1.pop_front();
            2: d = mq2.pop_front();
            default: d = mq3.pop_front();
        endcase
        sb.push_back({CW'(q), d});
    endtask

    function automatic logic [PW:0] occ(input int q);
        return occupancy[q*(PW+1) +: (PW+1)];
    endfunction

    task automatic push(input int q, input logic [DW-1:0] d);
        chk("push_ready", 32'(push_ready[q]), 32'(msize(q) < DP));
        push_valid[q] = 1'b1;
        push_data[q*DW +: DW] = d;
        if (msize(q) < DP) mpush(q, d);
        tick();
        push_valid = '0;
    endtask

    task automatic check_out();
        logic [CW+DW-1:0] exp;
        chk("out_valid", 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            exp = sb.pop_front();
            chk("out_id_data", 32'({out_id, out_data}), 32'(exp));
        end
    endtask

    task automatic grant(input int q);
        gnt = NQ'(1) << q;
        #1;
        chk("reqs_before_gnt", 32'(reqs[q]), 32'(msize(q) > 0));
        mpop_to_sb(q);
        tick();
        gnt = '0;
        check_out();
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_reqs", 32'(reqs), 32'd0);
        chk("rst_pready", 32'(push_ready), 32'hF);
        rst = 1'b0;
        tick();
        chk("init_blk", 32'(blk), 32'd0);
        chk("init_ovalid", 32'(out_valid), 32'd0);
        chk("init_err", 32'(err), 32'd0);

        // reset mid-traffic, with a held output packet
        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        push(0, 8'h04);
        chk("q0_occ4", 32'(occ(0)), 32'd4);
        out_ready = 1'b0;
        grant(0);
        chk("q0_occ3", 32'(occ(0)), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("amid_occ", 32'(occupancy), 32'd0);
        chk("amid_reqs", 32'(reqs), 32'd0);
        chk("amid_ovalid", 32'(out_valid), 32'd0);
        chk("amid_err", 32'(err), 32'd0);
        chk("amid_pready", 32'(push_ready), 32'hF);
        mq0.delete();
        out_ready = 1'b1;
        #1;
        rst = 1'b0;
        tick();

        // single flow on queue 2
        push(2, 8'h11);
        push(2, 8'h22);
        chk("q2_reqs", 32'(reqs), 32'h4);
        grant(2);
        grant(2);
        chk("q2_reqs_low", 32'(reqs[2]), 32'd0);
        tick();
        chk("q2_ovalid_clr", 32'(out_valid), 32'd0);

        // full and pointer wrap on queue 1
        for (int k = 0; k < 5; k++) push(1, 8'hA0 + 8'(k));
        chk("q1_full_occ", 32'(occ(1)), 32'd4);
        grant(1);
        grant(1);
        push(1, 8'hB0);
        push(1, 8'hB1);
        chk("q1_refill_occ", 32'(occ(1)), 32'd4);
        for (int k = 0; k < 4; k++) grant(1);
        chk("q1_drained", 32'(occ(1)), 32'd0);

        // backpressure
        push(0, 8'h55);
        push(0, 8'h66);
        out_ready = 1'b0;
        grant(0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_blk", 32'(blk), 32'd1);
            chk("bp_reqs", 32'(reqs), 32'd0);
            chk("bp_hold", 32'({out_valid, out_id, out_data}), 32'({1'b1, 2'd0, 8'h55}));
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_blk", 32'(blk), 32'd0);
        chk("bp_release_reqs", 32'(reqs), 32'h1);
        grant(0);

        // simultaneous push and pop on queue 3
        push(3, 8'h31);
        push(3, 8'h32);
        chk("q3_occ2", 32'(occ(3)), 32'd2);
        push_valid[3] = 1'b1;
        push_data[3*DW +: DW] = 8'h33;
        gnt = 4'b1000;
        mpop_to_sb(3);
        mpush(3, 8'h33);
        tick();
        push_valid = '0;
        gnt = '0;
        check_out();
        chk("q3_occ_same", 32'(occ(3)), 32'd2);
        grant(3);
        grant(3);
        tick();

        // protocol errors
        push(0, 8'h70);
        push(1, 8'h71);
        chk("pre_err", 32'(err), 32'd0);
        gnt = 4'b0011;
        tick();
        gnt = '0;
        chk("multi_err", 32'(err), 32'd1);
        chk("multi_nopop", 32'(out_valid), 32'd0);
        chk("multi_occ", 32'(occupancy), 32'(12'b000_000_001_001));
        grant(0);
        gnt = 4'b0001;
        tick();
        gnt = '0;
        chk("empty_gnt_err", 32'(err), 32'd1);
        chk("empty_gnt_nopop", 32'(out_valid), 32'd0);
        chk("empty_gnt_occ", 32'(occupancy), 32'(12'b000_000_001_000));
        grant(1);
        tick();
        chk("err_sticky", 32'(err), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
